video_timing_generator: RTL and testbench
=========================================

// Module: video_timing_generator
// PURPOSE
//  Raster timing source for the HDMI/DVI video path; default mode is 1280x720@60 (74.25 MHz pixel clock).
//  Produces the pixel/line counters consumed directly by the test pattern stage, plus hsync, vsync,
//  active-draw, a new-frame strobe and a frame counter.
//  Registers the 2-bit pattern select once per frame, so a pattern change never tears mid-frame.
// PARAMETERS
//  H_ACTIVE   1280  visible pixels per line
//  H_FP       110   horizontal front porch, pixels
//  H_SYNC     40    hsync width, pixels
//  H_BP       220   horizontal back porch, pixels
//  V_ACTIVE   720   visible lines per frame
//  V_FP       5     vertical front porch, lines
//  V_SYNC     5     vsync width, lines
//  V_BP       20    vertical back porch, lines
//  SYNC_POL   1     1: syncs active-high; 0: active-low
//  FC_WIDTH   6     frame counter width
//  derived: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (1650)
//  derived: V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (750)
//  derived: HW=$clog2(H_TOTAL) (11), VW=$clog2(V_TOTAL) (10)
// PORTS
//  i_clk          in   1         pixel clock
//  i_rst_n        in   1         asynchronous reset, active-low
//  i_en           in   1         pixel enable; when 0 every register holds
//  i_sel          in   2         requested pattern select, any time
//  o_hcount       out  HW        pixel index in line, 0..H_TOTAL-1
//  o_vcount       out  VW        line index in frame, 0..V_TOTAL-1
//  o_hsync        out  1         horizontal sync, polarity per SYNC_POL
//  o_vsync        out  1         vertical sync, polarity per SYNC_POL
//  o_active_draw  out  1         1 iff hcount<H_ACTIVE and vcount<V_ACTIVE
//  o_new_frame    out  1         1-cycle strobe at the start of vertical blank
//  o_frame_count  out  FC_WIDTH  frames completed, wraps
//  o_sel          out  2         frame-stable pattern select
// BEHAVIOUR
//  - One clock domain. Reset is asynchronous and active-low.
//  - All outputs are registered, with no combinational path from input to output.
//  - The decoded outputs (sync, active, strobe) always describe the o_hcount/o_vcount value of the same cycle.
//    To achieve this they are decoded from the next-state counts.
//  - Reset state is the last blanking pixel:
//    - hcount=H_TOTAL-1, vcount=V_TOTAL-1
//    - hsync=vsync=~SYNC_POL (deasserted); active_draw=0; new_frame=0
//    - frame_count=0; o_sel=0
//  - First enabled clock after reset release moves the counters to (0,0) with active_draw=1.
//  - Counting (on clock when i_en=1):
//    - hcount increments by 1 per clock.
//    - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
//    - At (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0.
//  - hsync asserted iff hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; default [1390,1429].
//  - vsync asserted iff vcount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; default [725,729].
//    vsync covers whole lines and is independent of hcount.
//  - new_frame=1 for exactly one enabled cycle, when (hcount,vcount)=(H_ACTIVE,V_ACTIVE).
//    - In that same cycle, frame_count is incremented (mod 2^FC_WIDTH) and o_sel takes i_sel.
//    - At all other times o_sel holds.
//  - i_en=0: all outputs hold their value, including a new_frame=1 strobe. The strobe is not re-issued.
//  - Reset mid-frame: all outputs return asynchronously to the reset state. No partial-frame state survives.
//  - o_hcount/o_vcount widths match the pattern stage's count input widths for the default mode.
// STRUCTURE
//  - Package video_timing_pkg holds:
//    - 720p defaults: H_ACTIVE..V_BP
//    - pattern-select constants (2'b00 solid, 2'b01 cross, 2'b10 ombre, 2'b11 multi-colour)
//    - a function computing H_TOTAL and V_TOTAL
//  - One sub-module, wrap_counter #(MAX, W), instantiated twice (h, v):
//    - inputs: clk, async rst_n, en
//    - outputs: count, and a combinational terminal-count flag
//    - the v instance's en = i_en & h terminal-count
//  - Sync/active/strobe decode stays in this module, registered.
// TESTING
//  1 Reset:
//    - hold i_rst_n=0, toggle i_clk -> hcount=1649, vcount=749, hsync=vsync=0, active=0, fc=0, sel=0.
//    - release -> next clk gives (0,0), active=1.
//  2 Line timing:
//    - run 1650 clk -> active=1 for hcount 0..1279.
//    - hsync=1 for exactly 40 clk, at hcount 1390..1429.
//    - at hcount 1649, vcount increments on the next clk.
//  3 Frame timing:
//    - run 1650*750 clk -> vsync=1 only on lines 725..729.
//    - new_frame=1 once, at (1280,720); fc 0->1; 1237500 clk between strobes.
//  4 Sel latch:
//    - change i_sel to 2'b10 at (100,300) -> o_sel unchanged until (1280,720), then 2'b10.
//    - i_sel glitch 11->01 mid-frame -> only the value at the strobe is captured.
//  5 Enable stall:
//    - drop i_en for 7 clk at hcount 1389 -> all outputs frozen 7 clk; hsync still lasts 40 enabled clk.
//    - stall on the new_frame cycle -> fc increments once.
//  6 Async reset mid-frame, plus wraps:
//    - assert i_rst_n=0 between clock edges at (640,360) -> outputs go to the reset state before the next edge.
//    - run 64 frames -> fc wraps 63->0.
//    - SYNC_POL=0 build -> hsync/vsync are inverted.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing source: 720p60 defaults, pattern
// select codes and the helper that sizes a line/frame from its four segments.
package video_timing_pkg;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;

  localparam logic [1:0] SEL_SOLID = 2'b00;
  localparam logic [1:0] SEL_CROSS = 2'b01;
  localparam logic [1:0] SEL_OMBRE = 2'b10;
  localparam logic [1:0] SEL_MULTI = 2'b11;

  function automatic int calc_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_generator_wrap_counter.sv
// Modulo (MAX+1) counter that resets to its terminal value, so the first
// enabled clock after reset lands on zero.
module wrap_counter #(
  parameter int MAX = 1649,
  parameter int W   = 11
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  localparam logic [W-1:0] LAST = W'(MAX);

  logic [W-1:0] r_count;

  assign o_tc    = (r_count == LAST);
  assign o_count = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= LAST;
    end else if (i_en) begin
      r_count <= o_tc ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing source: pixel/line counters plus registered sync, active,
// new-frame strobe, frame counter and a per-frame latched pattern select.
module video_timing_generator
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = 1,
  parameter int FC_WIDTH = 6,
  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [1:0]          i_sel,
  output logic [HW-1:0]       o_hcount,
  output logic [VW-1:0]       o_vcount,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_active_draw,
  output logic                o_new_frame,
  output logic [FC_WIDTH-1:0] o_frame_count,
  output logic [1:0]          o_sel
);

  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          SYNC_ON  = (SYNC_POL != 0);

  function automatic logic sync_level(input logic on);
    return SYNC_ON ? on : ~on;
  endfunction

  logic          w_h_tc;
  logic          w_v_tc;
  logic          w_v_en;
  logic [HW-1:0] w_h_count;
  logic [VW-1:0] w_v_count;
  logic [HW-1:0] w_h_next;
  logic [VW-1:0] w_v_next;
  logic          w_hs_on;
  logic          w_vs_on;
  logic          w_active;
  logic          w_frame;

  logic                r_hsync;
  logic                r_vsync;
  logic                r_active;
  logic                r_new_frame;
  logic [FC_WIDTH-1:0] r_frame_count;
  logic [1:0]          r_sel;

  assign w_v_en = i_en & w_h_tc;

  wrap_counter #(.MAX(H_TOTAL - 1), .W(HW)) u_hcnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .o_count (w_h_count),
    .o_tc    (w_h_tc)
  );

  wrap_counter #(.MAX(V_TOTAL - 1), .W(VW)) u_vcnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_v_en),
    .o_count (w_v_count),
    .o_tc    (w_v_tc)
  );

  // Decode from the counts the counters are about to take, so the registered
  // flags line up with the registered counts in the same cycle.
  assign w_h_next = w_h_tc ? '0 : w_h_count + 1'b1;
  assign w_v_next = !w_h_tc ? w_v_count : (w_v_tc ? '0 : w_v_count + 1'b1);

  assign w_hs_on  = (w_h_next >= HS_FIRST) && (w_h_next <= HS_LAST);
  assign w_vs_on  = (w_v_next >= VS_FIRST) && (w_v_next <= VS_LAST);
  assign w_active = (w_h_next < H_ACT) && (w_v_next < V_ACT);
  assign w_frame  = (w_h_next == H_ACT) && (w_v_next == V_ACT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hsync       <= ~SYNC_ON;
      r_vsync       <= ~SYNC_ON;
      r_active      <= 1'b0;
      r_new_frame   <= 1'b0;
      r_frame_count <= '0;
      r_sel         <= SEL_SOLID;
    end else if (i_en) begin
      r_hsync     <= sync_level(w_hs_on);
      r_vsync     <= sync_level(w_vs_on);
      r_active    <= w_active;
      r_new_frame <= w_frame;
      if (w_frame) begin
        r_frame_count <= r_frame_count + 1'b1;
        r_sel         <= i_sel;
      end
    end
  end

  assign o_hcount      = w_h_count;
  assign o_vcount      = w_v_count;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_active_draw = r_active;
  assign o_new_frame   = r_new_frame;
  assign o_frame_count = r_frame_count;
  assign o_sel         = r_sel;

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench for video_timing_generator on a shrunken raster (28x17) with both sync
// polarities, checked every cycle against a linear-pixel-index model.
module tb_video_timing_generator;

  localparam int HA = 16, HFP = 3, HSW = 4, HBP = 5;
  localparam int VA = 10, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;   // 28
  localparam int VT = VA + VFP + VSW + VBP;   // 17
  localparam int FRAME = HT * VT;             // 476
  localparam int STROBE = VA * HT + HA;       // linear index of (16,10)
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [1:0] sel = 2'b11;

  logic [HW-1:0] h0, h1;
  logic [VW-1:0] v0, v1;
  logic hs0, hs1, vs0, vs1, act0, act1, nf0, nf1;
  logic [5:0] fc0, fc1;
  logic [1:0] sel0, sel1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit cmp_on = 1'b0;

  int m_p = FRAME - 1;
  logic [5:0] m_fc = '0;
  logic [1:0] m_sel = '0;

  always #5 clk = ~clk;

  video_timing_generator #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(1), .FC_WIDTH(6)
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sel(sel),
    .o_hcount(h0), .o_vcount(v0), .o_hsync(hs0), .o_vsync(vs0),
    .o_active_draw(act0), .o_new_frame(nf0), .o_frame_count(fc0), .o_sel(sel0)
  );

  video_timing_generator #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(0), .FC_WIDTH(6)
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sel(sel),
    .o_hcount(h1), .o_vcount(v1), .o_hsync(hs1), .o_vsync(vs1),
    .o_active_draw(act1), .o_new_frame(nf1), .o_frame_count(fc1), .o_sel(sel1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int e_h(input int p); return p % HT; endfunction
  function automatic int e_v(input int p); return p / HT; endfunction
  function automatic int e_hs(input int p);
    return int'((e_h(p) >= HA + HFP) && (e_h(p) < HA + HFP + HSW));
  endfunction
  function automatic int e_vs(input int p);
    return int'((e_v(p) >= VA + VFP) && (e_v(p) < VA + VFP + VSW));
  endfunction
  function automatic int e_act(input int p);
    return int'((e_h(p) < HA) && (e_v(p) < VA));
  endfunction

  // Model: raster position as a single index into the frame.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p   <= FRAME - 1;
      m_fc  <= '0;
      m_sel <= '0;
    end else if (en) begin
      m_p <= (m_p + 1) % FRAME;
      if ((m_p + 1) % FRAME == STROBE) begin
        m_fc  <= m_fc + 6'd1;
        m_sel <= sel;
      end
    end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (cmp_on) begin
      chk("hcount", int'(h0), e_h(m_p));
      chk("vcount", int'(v0), e_v(m_p));
      chk("hsync", int'(hs0), e_hs(m_p));
      chk("vsync", int'(vs0), e_vs(m_p));
      chk("active", int'(act0), e_act(m_p));
      chk("new_frame", int'(nf0), int'(m_p == STROBE));
      chk("frame_count", int'(fc0), int'(m_fc));
      chk("sel", int'(sel0), int'(m_sel));
      chk("neg_hcount", int'(h1), e_h(m_p));
      chk("neg_vcount", int'(v1), e_v(m_p));
      chk("neg_hsync", int'(hs1), 1 - e_hs(m_p));
      chk("neg_vsync", int'(vs1), 1 - e_vs(m_p));
      chk("neg_active", int'(act1), e_act(m_p));
      chk("neg_new_frame", int'(nf1), int'(m_p == STROBE));
      chk("neg_frame_count", int'(fc1), int'(m_fc));
      chk("neg_sel", int'(sel1), int'(m_sel));
    end
  end

  initial begin
    int n, na, nh, first, t_prev;

    // Reset held with the clock running
    @(posedge clk);
    cmp_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hcount", int'(h0), 27);
    chk("rst_vcount", int'(v0), 16);
    chk("rst_hsync", int'(hs0), 0);
    chk("rst_vsync", int'(vs0), 0);
    chk("rst_active", int'(act0), 0);
    chk("rst_new_frame", int'(nf0), 0);
    chk("rst_fc", int'(fc0), 0);
    chk("rst_sel", int'(sel0), 0);
    chk("rst_neg_hsync", int'(hs1), 1);
    rst_n = 1'b1;
    en = 1'b1;
    @(negedge clk);
    chk("first_hcount", int'(h0), 0);
    chk("first_vcount", int'(v0), 0);
    chk("first_active", int'(act0), 1);

    // One full line
    na = 0; nh = 0; first = -1;
    for (int i = 0; i < HT; i++) begin
      if (act0) na++;
      if (hs0) begin
        nh++;
        if (first < 0) first = int'(h0);
      end
      @(negedge clk);
    end
    chk("line_active_cnt", na, 16);
    chk("line_hsync_cnt", nh, 4);
    chk("line_hsync_start", first, 19);
    chk("line_next_v", int'(v0), 1);
    chk("line_next_h", int'(h0), 0);

    // Pattern select changed mid-frame is taken only at the strobe
    sel = 2'b10;
    n = 0;
    while (!nf0 && n < 1000) begin @(negedge clk); n++; end
    chk("wait_strobe1", int'(n < 1000), 1);
    chk("strobe_h", int'(h0), 16);
    chk("strobe_v", int'(v0), 10);
    chk("strobe_sel", int'(sel0), 2);
    chk("strobe_fc", int'(fc0), 1);
    t_prev = cyc;
    sel = 2'b11;
    repeat (3) @(negedge clk);
    sel = 2'b01;
    n = 0;
    while (!nf0 && n < 1000) begin @(negedge clk); n++; end
    chk("wait_strobe2", int'(n < 1000), 1);
    chk("strobe_period", cyc - t_prev, 476);
    chk("glitch_sel", int'(sel0), 1);
    chk("strobe2_fc", int'(fc0), 2);

    // Stall on the strobe cycle
    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall_nf_held", int'(nf0), 1);
    chk("stall_fc", int'(fc0), 2);
    chk("stall_h", int'(h0), 16);
    en = 1'b1;
    @(negedge clk);
    chk("unstall_nf", int'(nf0), 0);
    chk("unstall_h", int'(h0), 17);
    chk("unstall_fc", int'(fc0), 2);

    // Stall just before hsync
    n = 0;
    while (h0 != 18 && n < 100) begin @(negedge clk); n++; end
    chk("wait_h18", int'(n < 100), 1);
    en = 1'b0;
    repeat (7) @(negedge clk);
    chk("hstall_h", int'(h0), 18);
    chk("hstall_hsync", int'(hs0), 0);
    en = 1'b1;
    nh = 0;
    repeat (HT) begin @(negedge clk); if (hs0) nh++; end
    chk("hstall_hsync_cnt", nh, 4);

    // Randomized enable and select
    repeat (25 * FRAME) begin
      @(negedge clk);
      en = ($urandom_range(0, 3) != 0);
      sel = 2'($urandom_range(0, 3));
    end

    // Asynchronous reset between edges
    en = 1'b1;
    n = 0;
    while (!(h0 == 8 && v0 == 5) && n < 1200) begin @(negedge clk); n++; end
    chk("wait_mid", int'(n < 1200), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hcount", int'(h0), 27);
    chk("arst_vcount", int'(v0), 16);
    chk("arst_active", int'(act0), 0);
    chk("arst_fc", int'(fc0), 0);
    chk("arst_sel", int'(sel0), 0);
    chk("arst_hsync", int'(hs0), 0);
    chk("arst_neg_hsync", int'(hs1), 1);
    chk("arst_nf", int'(nf0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame counter wrap
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      n = 0;
      while (!nf0 && n < 1000) begin @(negedge clk); n++; end
      chk("wait_wrap_strobe", int'(n < 1000), 1);
      if (k == 63) chk("fc_63", int'(fc0), 63);
      if (k == 64) chk("fc_wrap", int'(fc0), 0);
      sel = 2'($urandom_range(0, 3));
    end

    @(negedge clk);
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
